mips_multicycle_ctrl: RTL

Multicycle control FSM for the MIPS simple core.
- Sequences one instruction at a time through fetch, decode, execute, memory and writeback.
- Drives every shared-datapath select: PC, IR, register file, ALU, memory port, and immediate extend mode (sign/zero/lui).
- Handshakes with a single shared instruction/data memory port.
- Counts retired instructions and traps on unsupported opcodes.

---
 rtl/mips_ctrl_pkg.sv | 95 +++++++++
 rtl/mips_ctrl_outdec.sv | 85 ++++++++
 rtl/mips_multicycle_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the MIPS multicycle control unit: FSM states,
// opcode constants, datapath select encodings and the control-vector type.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC,
    S_ALUWB,
    S_BRANCH,
    S_JUMP,
    S_IMMEX,
    S_IMMWB,
    S_TRAP
  } state_e;

  // Supported opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // PC source select
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // ALU B-operand select
  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // ALU operation class
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_IMM   = 2'b11;

  // Immediate extension mode
  localparam logic [1:0] EXT_SIGN = 2'b00;
  localparam logic [1:0] EXT_ZERO = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  // Complete set of datapath controls driven by the FSM
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] ext_mode;
    logic       illegal;
  } ctrl_t;

  // State reached from DECODE for a given opcode
  function automatic state_e dispatch_state(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW:                             return S_MEMADR;
      OP_RTYPE:                                 return S_EXEC;
      OP_BEQ, OP_BNE:                           return S_BRANCH;
      OP_J:                                     return S_JUMP;
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: return S_IMMEX;
      default:                                  return S_TRAP;
    endcase
  endfunction

  // Logical immediates zero-extend, lui shifts, arithmetic sign-extends
  function automatic logic [1:0] imm_ext_mode(input logic [5:0] op);
    case (op)
      OP_ANDI, OP_ORI: return EXT_ZERO;
      OP_LUI:          return EXT_LUI;
      default:         return EXT_SIGN;
    endcase
  endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Combinational decoder from FSM state and latched opcode to the raw
// control vector. Write strobes that depend on the memory handshake or the
// branch condition are produced unqualified here; the top gates them.
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_e      state_i,
  input  logic [5:0]  op_i,
  output ctrl_t       ctrl_o
);

  // Per-state control vector, everything inactive unless the state sets it
  always_comb begin
    // NOTE: the all-zero default ahead of the case keeps every field assigned on every path, so no latch is inferred.
    ctrl_o = '0;
    unique case (state_i)
      S_FETCH: begin
        ctrl_o.mem_req   = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.pc_src    = PC_SRC_ALU;
        ctrl_o.ir_write  = 1'b1;
        ctrl_o.pc_write  = 1'b1;
      end
      S_DECODE: begin
        ctrl_o.alu_src_b = SRCB_IMM_SH2;
        ctrl_o.ext_mode  = EXT_SIGN;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_MEMADR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.ext_mode  = EXT_SIGN;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        ctrl_o.mem_req = 1'b1;
        ctrl_o.iord    = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.mem_req = 1'b1;
        ctrl_o.mem_we  = 1'b1;
        ctrl_o.iord    = 1'b1;
      end
      S_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_RT;
        ctrl_o.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_RT;
        ctrl_o.alu_op    = ALU_SUB;
        ctrl_o.pc_src    = PC_SRC_ALUOUT;
        ctrl_o.pc_write  = 1'b1;
      end
      S_JUMP: begin
        ctrl_o.pc_write = 1'b1;
        ctrl_o.pc_src   = PC_SRC_JUMP;
      end
      S_IMMEX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALU_IMM;
        ctrl_o.ext_mode  = imm_ext_mode(op_i);
      end
      S_IMMWB: begin
        ctrl_o.reg_write = 1'b1;
      end
      S_TRAP: begin
        ctrl_o.illegal = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle control FSM for the MIPS simple core. Holds the state, the
// opcode latched in DECODE and the retired-instruction counter, and
// qualifies handshake/branch strobes on top of the decoded control vector.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       ext_mode,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_e           state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire;
  logic             take_branch;
  ctrl_t            ctrl_raw;
  ctrl_t            ctrl;

  // funct is decoded by the ALU control, not here
  logic unused_funct;
  assign unused_funct = ^funct;

  mips_ctrl_outdec u_outdec (
    .state_i (state_q),
    .op_i    (op_q),
    .ctrl_o  (ctrl_raw)
  );

  // Next state, opcode latch and retire pulse
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    retire  = 1'b0;
    unique case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        op_d    = opcode;
        state_d = dispatch_state(opcode);
      end
      S_MEMADR: state_d = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWR: begin
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC:   state_d = S_ALUWB;
      S_IMMEX:  state_d = S_IMMWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_IMMWB: begin
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
    retired_d = retired_q + CNT_W'(retire);
  end

  // State, opcode and counter registers with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      retired_q <= retired_d;
    end
  end

  // Gate handshake- and condition-dependent strobes; reset silences all
  always_comb begin
    take_branch = ((op_q == OP_BEQ) &  alu_zero) |
                  ((op_q == OP_BNE) & ~alu_zero);
    ctrl = ctrl_raw;
    if (state_q == S_FETCH) begin
      ctrl.ir_write = ctrl_raw.ir_write & mem_ready;
      ctrl.pc_write = ctrl_raw.pc_write & mem_ready;
    end
    if (state_q == S_BRANCH) begin
      ctrl.pc_write = ctrl_raw.pc_write & take_branch;
    end
    if (!rst_n) begin
      ctrl = '0;
    end
  end

  assign mem_req    = ctrl.mem_req;
  assign mem_we     = ctrl.mem_we;
  assign iord       = ctrl.iord;
  assign ir_write   = ctrl.ir_write;
  assign pc_write   = ctrl.pc_write;
  assign pc_src     = ctrl.pc_src;
  assign reg_write  = ctrl.reg_write;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign ext_mode   = ctrl.ext_mode;
  assign illegal    = ctrl.illegal;
  assign retired    = retired_q;

endmodule
